// File: rtl/tlb_pkg.sv
// Shared TLB maintenance constants: array size, op encodings, FSM states.
// CP0 Index word helper used when a probe result is written back.
package tlb_pkg;

    localparam int TLB_NUM     = 32;
    localparam int IDX_W       = $clog2(TLB_NUM);
    localparam int INDEX_P_BIT = 31;

    localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_NUM - 1);

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } tlb_state_e;

    // P is set on a probe miss; the index field reads back as zero in that case.
    function automatic logic [31:0] index_word(input logic found, input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        w              = '0;
        w[INDEX_P_BIT] = ~found;
        w[IDX_W-1:0]   = found ? idx : '0;
        return w;
    endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Pipeline/CP0 and TLB-array signals seen by the maintenance controller.
// master = pipeline/CP0/array side, slave = controller.
interface tlb_maint_ctrl_if;
    import tlb_pkg::*;

    logic             op_valid;
    logic [1:0]       op_type;
    logic             cancel;
    logic             op_ready;
    logic             stall_o;
    logic [IDX_W-1:0] wired_i;
    logic             wired_we;
    logic [IDX_W-1:0] random_o;
    logic             tlb_found;
    logic [IDX_W-1:0] tlb_s_index;
    logic             tlb_re;
    logic             tlb_wi;
    logic             tlb_wr;
    logic [IDX_W-1:0] tlb_w_random;
    logic             index_we;
    logic [31:0]      index_wdata;
    logic             entry_we;
    logic             refetch_o;
    logic             done_o;

    modport master (
        output op_valid, op_type, cancel, wired_i, wired_we, tlb_found, tlb_s_index,
        input  op_ready, stall_o, random_o, tlb_re, tlb_wi, tlb_wr, tlb_w_random,
               index_we, index_wdata, entry_we, refetch_o, done_o
    );

    modport slave (
        input  op_valid, op_type, cancel, wired_i, wired_we, tlb_found, tlb_s_index,
        output op_ready, stall_o, random_o, tlb_re, tlb_wi, tlb_wr, tlb_w_random,
               index_we, index_wdata, entry_we, refetch_o, done_o
    );

endinterface

// File: rtl/tlb_random_cnt.sv
// CP0 Random: free-running down-counter that wraps from Wired back to TLB_NUM-1.
// Latency: 1 cycle per update. Backpressure: none, counts every cycle.
// Wired writes reload to the top; a Wired at or above the top pins it there.
module tlb_random_cnt
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    always_ff @(posedge clk) begin
        if (rst) begin
            random <= RAND_MAX;
        end else if (wired_we || (wired >= RAND_MAX) || (random == wired)) begin
            random <= RAND_MAX;
        end else begin
            random <= random - IDX_W'(1);
        end
    end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the TLB array and writes results to CP0.
// Latency: accept T, array strobe T+1, CP0 update/done T+2, ready again T+3.
// Backpressure: op_ready low and stall_o high while an op is in flight.
module tlb_maint_ctrl
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    tlb_maint_ctrl_if.slave  bus
);

    tlb_state_e       state;
    tlb_op_e          op_q;
    logic             re_q, wi_q, wr_q;
    logic             index_we_q, entry_we_q, refetch_q, done_q;
    logic [31:0]      index_wdata_q;
    logic [IDX_W-1:0] w_random_q;
    logic [IDX_W-1:0] random;
    logic             accept;
    tlb_op_e          op_in;

    assign op_in  = tlb_op_e'(bus.op_type);
    assign accept = (state == ST_IDLE) && bus.op_valid && !bus.cancel;

    tlb_random_cnt u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (bus.wired_i),
        .wired_we (bus.wired_we),
        .random   (random)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            op_q          <= OP_TLBP;
            re_q          <= 1'b0;
            wi_q          <= 1'b0;
            wr_q          <= 1'b0;
            index_we_q    <= 1'b0;
            entry_we_q    <= 1'b0;
            refetch_q     <= 1'b0;
            done_q        <= 1'b0;
            index_wdata_q <= '0;
            w_random_q    <= RAND_MAX;
        end else begin
            re_q       <= 1'b0;
            wi_q       <= 1'b0;
            wr_q       <= 1'b0;
            index_we_q <= 1'b0;
            entry_we_q <= 1'b0;
            refetch_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_EXEC;
                        op_q       <= op_in;
                        w_random_q <= random;
                        re_q       <= (op_in == OP_TLBR);
                        wi_q       <= (op_in == OP_TLBWI);
                        wr_q       <= (op_in == OP_TLBWR);
                    end
                end
                ST_EXEC: begin
                    state  <= ST_RESP;
                    done_q <= 1'b1;
                    case (op_q)
                        OP_TLBP: begin
                            index_we_q    <= 1'b1;
                            index_wdata_q <= index_word(bus.tlb_found, bus.tlb_s_index);
                        end
                        // Keep re asserted so the array's read outputs stay valid for CP0.
                        OP_TLBR: begin
                            re_q       <= 1'b1;
                            entry_we_q <= 1'b1;
                        end
                        OP_TLBWI, OP_TLBWR: refetch_q <= 1'b1;
                    endcase
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are masked during reset so an in-flight op cannot touch the array or CP0.
    assign bus.tlb_re       = re_q & ~rst;
    assign bus.tlb_wi       = wi_q & ~rst;
    assign bus.tlb_wr       = wr_q & ~rst;
    assign bus.index_we     = index_we_q & ~rst;
    assign bus.entry_we     = entry_we_q & ~rst;
    assign bus.refetch_o    = refetch_q & ~rst;
    assign bus.done_o       = done_q & ~rst;
    assign bus.index_wdata  = index_wdata_q;
    assign bus.tlb_w_random = w_random_q;
    assign bus.random_o     = random;
    assign bus.op_ready     = (state == ST_IDLE);
    assign bus.stall_o      = accept || (state != ST_IDLE);

endmodule

// File: doc/tlb_maint_ctrl.md
# tlb_maint_ctrl

Sequencer for MIPS TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) issued from the MEM stage. Sits between the pipeline/CP0 and the 32-entry `tlb` array. It drives the array's `re`/`wi`/`wr`/`w_random_i` controls, captures probe and read results into CP0, and owns the CP0 Random register. It holds the pipeline stalled for the fixed operation latency and requests a refetch after every TLB write.

## Interface
- `TLB_NUM`, 32: number of TLB entries.
- `IDX_W`, $clog2(TLB_NUM): index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `op_valid`  in  1  maintenance op present in MEM.
- `op_type`  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
- `cancel`  in  1  exception/flush in MEM this cycle; blocks acceptance.
- `op_ready`  out  1  controller idle; op accepted when `op_valid & op_ready & ~cancel`.
- `stall_o`  out  1  pipeline stall request.
- `wired_i`  in  IDX_W  CP0 Wired value.
- `wired_we`  in  1  CP0 Wired write strobe.
- `random_o`  out  IDX_W  CP0 Random value.
- `tlb_found`, `tlb_s_index`  in  1 / IDX_W  probe result from the array.
- `tlb_re`, `tlb_wi`, `tlb_wr`  out  1 each  array strobes.
- `tlb_w_random`  out  IDX_W  write index for TLBWR.
- `index_we`  out  1  load CP0 Index.
- `index_wdata`  out  32  {P, 0…, index}.
- `entry_we`  out  1  load EntryHi/EntryLo0/1/PageMask from array `r_*`.
- `refetch_o`  out  1  refetch from PC+4 after a TLB write.
- `done_o`  out  1  operation complete.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC on accept; the op type is latched.
  - EXEC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- EXEC drives exactly one strobe for one cycle:
  - TLBR: `tlb_re`.
  - TLBWI: `tlb_wi`.
  - TLBWR: `tlb_wr`.
  - TLBP: no strobe; `tlb_found`/`tlb_s_index` are registered at the end of EXEC.
- RESP pulses, for one cycle:
  - TLBP: `index_we`, with `index_wdata[31] = ~found`, low bits = s_index (0 when not found), other bits 0.
  - TLBR: `entry_we`. `tlb_re` is also held high in RESP so the `r_*` outputs stay valid.
  - TLBWI/TLBWR: `refetch_o`.
  - All ops: `done_o`.
- Random register:
  - Reset value TLB_NUM-1.
  - Decrements every cycle; when Random == `wired_i`, the next value is TLB_NUM-1.
  - `wired_we` forces TLB_NUM-1 (priority over decrement).
  - If `wired_i` ≥ TLB_NUM-1, Random holds TLB_NUM-1.
- TLBWR index is the Random value snapshotted at accept. `tlb_w_random` is held from the snapshot through EXEC, and Random keeps counting.
- `cancel` during IDLE suppresses accept. Once accepted, an op always completes; `cancel` is ignored in EXEC/RESP.
- `rst` mid-operation returns the FSM to IDLE; no strobe fires in the reset cycle.

## Timing
- Accept in cycle T, EXEC in T+1, RESP in T+2, `op_ready` high again in T+3.
- `stall_o` is combinational: `(IDLE & op_valid & ~cancel) | EXEC | RESP`. It is high in T, T+1 and T+2.
- Back-to-back ops: the next op can be accepted in T+3 at the earliest.
- Reset values: FSM IDLE, `op_ready`=1, Random=TLB_NUM-1. All strobes, `stall_o`, `index_wdata`, `refetch_o` and `done_o` are 0.
- All outputs except `stall_o` and `op_ready` are registered or decoded from registered state, with no combinational path from `op_valid`.

## Structure
- Shared package `tlb_pkg`:
  - `TLB_NUM`.
  - op encodings `OP_TLBP`/`OP_TLBR`/`OP_TLBWI`/`OP_TLBWR`.
  - FSM state encoding.
  - Index P-bit position (31).
- One sub-module, `tlb_random_cnt`: Random counter with its Wired/`wired_we` handling. The FSM stays in the top module.

## Test plan
- TLBP hit: entry 5 matches (found=1, s_index=5), accept at T → `index_we` at T+2 with `index_wdata` = 0x0000_0005; `stall_o` high for T..T+2.
- TLBP miss: found=0 → `index_wdata` = 0x8000_0000 at T+2, no other strobes.
- TLBWR with wired_i=4: free-running Random passes 4 → next value 31. Accept when Random=7 → `tlb_wr` at T+1 with `tlb_w_random`=7, `refetch_o` and `done_o` at T+2.
- `wired_we` asserted when Random=12 → Random=31 next cycle. wired_i=31 → Random stays 31 over 40 cycles.
- `op_valid` with `cancel`=1 → no accept and `stall_o`=0. `cancel` asserted at T+1 after a TLBWI accept → `tlb_wi` still fires at T+1.
- `rst` at T+1 of a TLBR → no `tlb_re` in that cycle, no `entry_we`, IDLE and `op_ready`=1 at T+2, Random=31.
